// File: rtl/lsu_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_if
//  Description : Load/store unit to single-port synchronous memory bridge.
//                Accepts one RV32I load/store at a time, issues a single
//                registered memory access, extracts/aligns load data and
//                returns a one-cycle response pulse. Illegal width codes are
//                rejected without touching memory.
//                Optional feature macro: LSU_MISALIGN_TRAP_EN
//                  defined   -> misaligned halfword/word accesses are rejected
//                  undefined -> offending low address bits are ignored
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_if #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    // core request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    // core response
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    // memory port
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteena,
    output logic [31:0]       mem_data,
    output logic              mem_enable,
    output logic              mem_wren,
    input  logic [31:0]       mem_q
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_CAPT  = 3'd2,
        S_RESP  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_we;
    logic [2:0]          r_funct3;
    logic [1:0]          r_off;

    logic [ADDR_W-1:0]   r_mem_address;
    logic [3:0]          r_mem_byteena;
    logic [31:0]         r_mem_data;
    logic                r_mem_enable;
    logic                r_mem_wren;

    logic                r_resp_valid;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;

    logic                w_bad_f3;
    logic                w_misalign;
    logic                w_illegal;
    logic [3:0]          w_be;
    logic [31:0]         w_data;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;

    // Byte-address bits above the memory window are not decoded.
    logic                w_unused;
    assign w_unused = &{1'b0, req_addr[31:ADDR_W+2]};

    // Classify the incoming request: unsupported width code or trapped misalignment.
    always_comb begin
        w_bad_f3   = 1'b0;
        w_misalign = 1'b0;
        if (req_we) begin
            w_bad_f3 = (req_funct3 > 3'b010);
        end else begin
            w_bad_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
`endif
        w_illegal = w_bad_f3 || w_misalign;
    end

    // Store lane steering; loads always read the whole word.
    always_comb begin
        w_be   = 4'b1111;
        w_data = 32'h0;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    w_be   = 4'b0001 << req_addr[1:0];
                    w_data = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    w_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                    w_data = {2{req_wdata[15:0]}};
                end
                default: begin
                    w_be   = 4'b1111;
                    w_data = req_wdata;
                end
            endcase
        end
    end

    // Load data extraction from the returned memory word.
    always_comb begin
        w_byte = 8'h0;
        w_load = 32'h0;
        case (r_off)
            2'd0:    w_byte = mem_q[7:0];
            2'd1:    w_byte = mem_q[15:8];
            2'd2:    w_byte = mem_q[23:16];
            default: w_byte = mem_q[31:24];
        endcase
        w_half = r_off[1] ? mem_q[31:16] : mem_q[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = mem_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; the core handshake is only open while idle.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_illegal ? S_ERR : S_ISSUE;
                end
            end
            S_ISSUE: w_next = r_we ? S_RESP : S_CAPT;
            S_CAPT:  w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture, memory drive and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we          <= 1'b0;
            r_funct3      <= 3'b000;
            r_off         <= 2'b00;
            r_mem_address <= '0;
            r_mem_byteena <= 4'b0000;
            r_mem_data    <= 32'h0;
            r_mem_enable  <= 1'b0;
            r_mem_wren    <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= 32'h0;
            r_resp_err    <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            r_mem_enable <= 1'b0;
            r_mem_wren   <= 1'b0;
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_off    <= req_addr[1:0];
                        if (w_illegal) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0;
                        end else begin
                            r_mem_address <= req_addr[ADDR_W+1:2];
                            r_mem_byteena <= w_be;
                            r_mem_data    <= w_data;
                            r_mem_enable  <= 1'b1;
                            r_mem_wren    <= req_we;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 32'h0;
                    end
                end
                S_CAPT: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= w_load;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_address = r_mem_address;
    assign mem_byteena = r_mem_byteena;
    assign mem_data    = r_mem_data;
    assign mem_enable  = r_mem_enable;
    assign mem_wren    = r_mem_wren;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_mem_if
//  Description : Self-checking bench for lsu_mem_if. A word memory answers the
//                DUT's memory port; expected results come from a byte-level
//                reference memory and the RV32I load/store rules.
//                Honours LSU_MISALIGN_TRAP_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_if;

    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteena;
    logic [31:0]       mem_data;
    logic              mem_enable;
    logic              mem_wren;
    logic [31:0]       mem_q = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_mem_if #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_address (mem_address),
        .mem_byteena (mem_byteena),
        .mem_data    (mem_data),
        .mem_enable  (mem_enable),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    // Word memory seen by the DUT: read-before-write, data one cycle later.
    logic [31:0] mem_words [0:63];
    logic [31:0] mem_tmp;
    always @(posedge clk) begin
        if (mem_enable === 1'b1) begin
            mem_q   <= mem_words[mem_address[5:0]];
            mem_tmp  = mem_words[mem_address[5:0]];
            if (mem_wren === 1'b1) begin
                for (int k = 0; k < 4; k++)
                    if (mem_byteena[k]) mem_tmp[8*k +: 8] = mem_data[8*k +: 8];
                mem_words[mem_address[5:0]] <= mem_tmp;
            end
        end
    end

    // Reference view of the same storage, byte addressed.
    logic [7:0] ref_bytes [0:255];

    task automatic set_word(input int w, input logic [31:0] v);
        mem_words[w] = v;
        for (int k = 0; k < 4; k++) ref_bytes[4*w + k] = v[8*k +: 8];
    endtask

    // One complete access; caller is positioned at a falling edge.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [7:0] a,
                          input logic [31:0] wd, input bit garbage, input string tag);
        bit          legal, mis, err;
        int          size, base, lat, w;
        int          en_cnt, rv_cnt, rv_cyc, en_cyc;
        logic [31:0] e_rdata, e_data, cap_rd, cap_data;
        logic [3:0]  e_be, cap_be;
        logic [ADDR_W-1:0] cap_addr;
        logic        cap_err, cap_wren;

        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis   = (int'(a) % size) != 0;
`endif
        err   = !legal || mis;
        base  = int'(a) - (int'(a) % size);
        lat   = err ? 1 : (we ? 2 : 3);
        e_be = 4'h0; e_data = 32'h0; e_rdata = 32'h0;
        if (!err && we) begin
            for (int i = 0; i < size; i++) e_be[(base % 4) + i] = 1'b1;
            for (int k = 0; k < 4; k++) e_data[8*k +: 8] = wd[8*(k % size) +: 8];
        end
        if (!err && !we) begin
            e_be = 4'hF;
            for (int i = 0; i < size; i++) e_rdata[8*i +: 8] = ref_bytes[base + i];
            if (!f3[2] && size == 1 && e_rdata[7])  e_rdata[31:8]  = 24'hFFFFFF;
            if (!f3[2] && size == 2 && e_rdata[15]) e_rdata[31:16] = 16'hFFFF;
        end

        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_wait: got %b want 1", tag, req_ready);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = {24'h0, a}; req_wdata = wd;

        en_cnt = 0; rv_cnt = 0; rv_cyc = -1; en_cyc = -1;
        cap_rd = 32'h0; cap_err = 1'b0; cap_addr = '0; cap_be = 4'h0;
        cap_data = 32'h0; cap_wren = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (mem_enable === 1'b1) begin
                en_cnt++; en_cyc = c;
                cap_addr = mem_address; cap_be = mem_byteena;
                cap_data = mem_data; cap_wren = mem_wren;
            end
            if (resp_valid === 1'b1) begin
                rv_cnt++;
                if (rv_cyc < 0) begin
                    rv_cyc = c; cap_rd = resp_rdata; cap_err = resp_err;
                end
            end
            if (garbage && c <= lat) begin
                req_valid = 1'b1; req_we = 1'($urandom);
                req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
            end else begin
                req_valid = 1'b0;
            end
        end

        n_cmp++;
        if (rv_cnt != 1 || rv_cyc != lat) begin
            n_bad++;
            $display("FAIL %s resp_timing: got %0d pulses first at %0d want 1 at %0d",
                     tag, rv_cnt, rv_cyc, lat);
        end
        n_cmp++;
        if (cap_err !== err) begin
            n_bad++;
            $display("FAIL %s resp_err: got %b want %b", tag, cap_err, err);
        end
        n_cmp++;
        if (cap_rd !== e_rdata) begin
            n_bad++;
            $display("FAIL %s resp_rdata: got %h want %h", tag, cap_rd, e_rdata);
        end
        n_cmp++;
        if (resp_rdata !== cap_rd || resp_err !== cap_err || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s hold_after_resp: got rdata %h err %b ready %b want %h %b 1",
                     tag, resp_rdata, resp_err, req_ready, cap_rd, cap_err);
        end
        n_cmp++;
        if (en_cnt != (err ? 0 : 1)) begin
            n_bad++;
            $display("FAIL %s mem_enable_count: got %0d want %0d", tag, en_cnt, err ? 0 : 1);
        end
        if (!err && en_cnt == 1) begin
            n_cmp++;
            if (en_cyc != 1 || cap_addr !== ADDR_W'(a >> 2) || cap_be !== e_be || cap_wren !== we) begin
                n_bad++;
                $display("FAIL %s mem_cmd: got cyc %0d addr %h be %b wren %b want 1 %h %b %b",
                         tag, en_cyc, cap_addr, cap_be, cap_wren, ADDR_W'(a >> 2), e_be, we);
            end
            if (we) begin
                n_cmp++;
                if (cap_data !== e_data) begin
                    n_bad++;
                    $display("FAIL %s mem_data: got %h want %h", tag, cap_data, e_data);
                end
            end
        end
        if (!err && we)
            for (int i = 0; i < size; i++) ref_bytes[base + i] = wd[8*i +: 8];
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
            resp_rdata !== 32'h0 || mem_enable !== 1'b0 || mem_wren !== 1'b0 ||
            mem_address !== '0 || mem_byteena !== 4'h0 || mem_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: got ready %b rv %b err %b rd %h en %b wr %b addr %h be %b d %h want 1 0 0 0 0 0 0 0 0",
                     req_ready, resp_valid, resp_err, resp_rdata, mem_enable, mem_wren,
                     mem_address, mem_byteena, mem_data);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_directed();
        do_txn(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 1'b0, "sw_0x10");
        set_word(4, 32'h0);
        do_txn(1'b1, 3'b000, 8'h13, 32'h000000A5, 1'b0, "sb_0x13");
        do_txn(1'b0, 3'b000, 8'h13, 32'h0, 1'b0, "lb_0x13");
        do_txn(1'b0, 3'b100, 8'h13, 32'h0, 1'b0, "lbu_0x13");
        set_word(8, 32'h80011234);
        do_txn(1'b0, 3'b001, 8'h22, 32'h0, 1'b0, "lh_0x22");
        do_txn(1'b0, 3'b101, 8'h22, 32'h0, 1'b0, "lhu_0x22");
        do_txn(1'b0, 3'b010, 8'h31, 32'h0, 1'b0, "lw_0x31");
        do_txn(1'b0, 3'b011, 8'h40, 32'h0, 1'b0, "load_f3_011");
        do_txn(1'b1, 3'b011, 8'h44, 32'h12345678, 1'b0, "store_f3_011");
        do_txn(1'b1, 3'b111, 8'h48, 32'h12345678, 1'b0, "store_f3_111");
        do_txn(1'b1, 3'b001, 8'h4B, 32'hCAFEF00D, 1'b0, "sh_odd");
        do_txn(1'b0, 3'b001, 8'h4B, 32'h0, 1'b0, "lh_odd");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            do_txn(1'($urandom), 3'($urandom_range(0, 5)), 8'($urandom),
                   $urandom, 1'b1, "b2b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            do_txn(1'($urandom), 3'($urandom), 8'($urandom), $urandom,
                   1'($urandom), "rand");
    endtask

    task automatic test_reset_in_capt();
        int seen;
        set_word(2, 32'h12345678);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
            resp_err !== 1'b0 || mem_enable !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_capt_state: got ready %b rv %b rd %h err %b en %b want 1 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err, mem_enable);
        end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL rst_capt_no_resp: got %0d pulses want 0", seen);
        end
    endtask

    task automatic test_reset_at_issue();
        int seen;
        logic [7:0]  a;
        logic [31:0] wd;
        a  = 8'($urandom_range(0, 63) * 4);
        wd = $urandom;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = {24'h0, a}; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (mem_enable !== 1'b1 || mem_wren !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_issue_cmd: got en %b wren %b want 1 1", mem_enable, mem_wren);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (resp_valid === 1'b1) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen != 0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_issue_no_resp: got %0d pulses ready %b want 0 1", seen, req_ready);
        end
        for (int k = 0; k < 4; k++) ref_bytes[int'(a) + k] = wd[8*k +: 8];
        do_txn(1'b0, 3'b010, a, 32'h0, 1'b0, "rst_issue_commit");
    endtask

    initial begin
        for (int w = 0; w < 64; w++) set_word(w, $urandom);
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_in_capt();
        test_reset_at_issue();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
